// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with a one-entry skid buffer and flush
// Optional PIPE_STAGE_STATS_EN adds a saturating stall_cnt output
module pipe_stage_reg #(
  parameter int DATA_W = 36,
  parameter int CTRL_W = 3
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);
  logic              m_v, s_v;
  logic [DATA_W-1:0] m_d, s_d;
  logic [CTRL_W-1:0] m_c, s_c;
  logic              acc, drn;
  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign out_ctrl  = m_c;
  assign acc       = in_valid & in_ready;
  assign drn       = m_v & out_ready;
  // control words are cleared whenever their entry leaves, so a bubble never carries control
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= '0;
      s_d <= '0;
      m_c <= '0;
      s_c <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_c <= '0;
      s_c <= '0;
    end else if (!m_v) begin
      if (acc) begin
        m_v <= 1'b1;
        m_d <= in_data;
        m_c <= in_ctrl;
      end
    end else if (!s_v) begin
      if (drn && acc) begin
        m_d <= in_data;
        m_c <= in_ctrl;
      end else if (drn) begin
        m_v <= 1'b0;
        m_c <= '0;
      end else if (acc) begin
        s_v <= 1'b1;
        s_d <= in_data;
        s_c <= in_ctrl;
      end
    end else if (drn) begin
      m_d <= s_d;
      m_c <= s_c;
      s_v <= 1'b0;
      s_c <= '0;
    end
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (m_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
`endif
endmodule
